// File: rtl/delay_line_ctrl.sv
// Runtime-programmable pixel delay line: circular buffer with frame-aligned depth switching.
// Define DELAY_CTRL_TAP2_EN to add a second tap (data2_o/valid2_o) at depth+TAP2_OFFSET.
module delay_line_ctrl #(
    parameter int WIDTH         = 24,
    parameter int MAX_DEPTH     = 64,
    parameter int AW            = 6,
    parameter int DEFAULT_DEPTH = 40,
    parameter int TAP2_OFFSET   = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [AW:0]      cfg_depth_i,
    input  logic             cfg_load_i,
    input  logic             frame_start_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [AW:0]      active_depth_o,
    output logic             pend_o,
    output logic             cfg_err_o
`ifdef DELAY_CTRL_TAP2_EN
    ,
    output logic [WIDTH-1:0] data2_o,
    output logic             valid2_o
`endif
);

    typedef enum logic {
        ST_RUN,
        ST_PEND
    } state_t;

    localparam logic [AW:0] D_ONE     = (AW+1)'(1);
    localparam logic [AW:0] MIN_DEPTH = (AW+1)'(2);
    localparam logic [AW:0] HIST_MAX  = (AW+1)'(MAX_DEPTH);
`ifdef DELAY_CTRL_TAP2_EN
    localparam logic [AW:0] MAX_CFG   = (AW+1)'(MAX_DEPTH - TAP2_OFFSET);
`else
    localparam logic [AW:0] MAX_CFG   = (AW+1)'(MAX_DEPTH);
`endif

    state_t           state;
    logic [WIDTH-1:0] mem [MAX_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      hist_cnt;
    logic [AW:0]      pend_depth;
    logic             cfg_ok;

    assign cfg_ok = (cfg_depth_i >= MIN_DEPTH) && (cfg_depth_i <= MAX_CFG);
    // Registered read: reading D-1 behind the write pointer lands the sample D cycles later.
    assign rd_ptr = wr_ptr - AW'(active_depth_o - D_ONE);

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr   <= '0;
            hist_cnt <= '0;
            data_o   <= '0;
            valid_o  <= 1'b0;
        end else begin
            if (en_i) begin
                wr_ptr  <= wr_ptr + AW'(1);
                data_o  <= mem[rd_ptr];
                valid_o <= (hist_cnt >= active_depth_o);
                if (hist_cnt != HIST_MAX) begin
                    hist_cnt <= hist_cnt + D_ONE;
                end
            end
            if (flush_i) begin
                hist_cnt <= '0;
                valid_o  <= 1'b0;
            end
        end
    end

`ifdef DELAY_CTRL_TAP2_EN
    logic [AW+1:0] depth2;
    logic [AW-1:0] rd2_ptr;

    assign depth2  = {1'b0, active_depth_o} + (AW+2)'(TAP2_OFFSET);
    assign rd2_ptr = wr_ptr - AW'(depth2 - (AW+2)'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data2_o  <= '0;
            valid2_o <= 1'b0;
        end else begin
            if (en_i) begin
                data2_o  <= mem[rd2_ptr];
                valid2_o <= ({1'b0, hist_cnt} >= depth2);
            end
            if (flush_i) begin
                valid2_o <= 1'b0;
            end
        end
    end
`else
    logic unused_tap2;
    assign unused_tap2 = ^TAP2_OFFSET;
`endif

    // A load in the same cycle as frame_start in PEND applies the old request and keeps the new one pending.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= ST_RUN;
            pend_depth     <= (AW+1)'(DEFAULT_DEPTH);
            active_depth_o <= (AW+1)'(DEFAULT_DEPTH);
            pend_o         <= 1'b0;
            cfg_err_o      <= 1'b0;
        end else begin
            cfg_err_o <= cfg_load_i && !cfg_ok;
            case (state)
                ST_RUN: begin
                    if (cfg_load_i && cfg_ok) begin
                        pend_depth <= cfg_depth_i;
                        state      <= ST_PEND;
                        pend_o     <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (frame_start_i) begin
                        active_depth_o <= pend_depth;
                    end
                    if (cfg_load_i && cfg_ok) begin
                        pend_depth <= cfg_depth_i;
                    end else if (frame_start_i) begin
                        state  <= ST_RUN;
                        pend_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    pend_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Randomized bench for delay_line_ctrl against a sample-history reference model.
// Build with +define+DELAY_CTRL_TAP2_EN to also cover the second tap.
module tb_delay_line_ctrl;

    localparam int WIDTH     = 24;
    localparam int MAX_DEPTH = 64;
    localparam int AW        = 6;
    localparam int DEF_DEPTH = 40;
    localparam int TAP2      = 6;
`ifdef DELAY_CTRL_TAP2_EN
    localparam int MAX_CFG   = MAX_DEPTH - TAP2;
`else
    localparam int MAX_CFG   = MAX_DEPTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en_i;
    logic [WIDTH-1:0] data_i;
    logic [AW:0]      cfg_depth_i;
    logic             cfg_load_i;
    logic             frame_start_i;
    logic             flush_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic [AW:0]      active_depth_o;
    logic             pend_o;
    logic             cfg_err_o;
`ifdef DELAY_CTRL_TAP2_EN
    logic [WIDTH-1:0] data2_o;
    logic             valid2_o;
`endif

    always #5 clk = ~clk;

    delay_line_ctrl #(
        .WIDTH(WIDTH),
        .MAX_DEPTH(MAX_DEPTH),
        .AW(AW),
        .DEFAULT_DEPTH(DEF_DEPTH),
        .TAP2_OFFSET(TAP2)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .en_i(en_i),
        .data_i(data_i),
        .cfg_depth_i(cfg_depth_i),
        .cfg_load_i(cfg_load_i),
        .frame_start_i(frame_start_i),
        .flush_i(flush_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .active_depth_o(active_depth_o),
        .pend_o(pend_o),
        .cfg_err_o(cfg_err_o)
`ifdef DELAY_CTRL_TAP2_EN
        ,
        .data2_o(data2_o),
        .valid2_o(valid2_o)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: every accepted sample in order, plus config bookkeeping.
    logic [WIDTH-1:0] samples[$];
    int               hcnt;
    int               d_act;
    int               d_pend;
    bit               pend;
    logic [WIDTH-1:0] exp_data;
    bit               data_known;
    bit               exp_valid;
    bit               exp_err;
    logic [WIDTH-1:0] exp_data2;
    bit               data2_known;
    bit               exp_valid2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit depth_ok(input int d);
        return (d >= 2) && (d <= MAX_CFG);
    endfunction

    task automatic model_reset();
        samples.delete();
        hcnt        = 0;
        d_act       = DEF_DEPTH;
        d_pend      = DEF_DEPTH;
        pend        = 1'b0;
        exp_data    = '0;
        data_known  = 1'b1;
        exp_valid   = 1'b0;
        exp_err     = 1'b0;
        exp_data2   = '0;
        data2_known = 1'b1;
        exp_valid2  = 1'b0;
    endtask

    task automatic model_edge();
        int  idx;
        int  dep;
        dep     = int'(cfg_depth_i);
        exp_err = cfg_load_i && !depth_ok(dep);
        if (en_i) begin
            idx = samples.size() - d_act + 1;
            if (idx >= 0) begin
                exp_data   = samples[idx];
                data_known = 1'b1;
            end else begin
                data_known = 1'b0;
            end
            exp_valid = (hcnt >= d_act);
            idx = samples.size() - (d_act + TAP2) + 1;
            if (idx >= 0) begin
                exp_data2   = samples[idx];
                data2_known = 1'b1;
            end else begin
                data2_known = 1'b0;
            end
            exp_valid2 = (hcnt >= d_act + TAP2);
            samples.push_back(data_i);
            if (hcnt < MAX_DEPTH) hcnt++;
        end
        if (flush_i) begin
            hcnt       = 0;
            exp_valid  = 1'b0;
            exp_valid2 = 1'b0;
        end
        if (pend && frame_start_i) begin
            d_act = d_pend;
            pend  = 1'b0;
        end
        if (cfg_load_i && depth_ok(dep)) begin
            d_pend = dep;
            pend   = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("valid_o", valid_o, exp_valid);
        if (data_known) check("data_o", data_o, exp_data);
        check("active_depth_o", active_depth_o, d_act);
        check("pend_o", pend_o, pend);
        check("cfg_err_o", cfg_err_o, exp_err);
`ifdef DELAY_CTRL_TAP2_EN
        check("valid2_o", valid2_o, exp_valid2);
        if (data2_known) check("data2_o", data2_o, exp_data2);
`endif
    endtask

    // One clock: drive at negedge, model the rising edge, compare at the next negedge.
    task automatic cyc(input bit en, input bit load, input int depth, input bit fs, input bit fl);
        en_i          = en;
        cfg_load_i    = load;
        cfg_depth_i   = (AW+1)'(depth);
        frame_start_i = fs;
        flush_i       = fl;
        data_i        = WIDTH'($urandom);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        en_i          = 1'b0;
        cfg_load_i    = 1'b0;
        frame_start_i = 1'b0;
        flush_i       = 1'b0;
        #2;
        model_reset();
        check("rst_data_o", data_o, 0);
        check("rst_valid_o", valid_o, 0);
        check("rst_active_depth_o", active_depth_o, DEF_DEPTH);
        check("rst_pend_o", pend_o, 0);
        check("rst_cfg_err_o", cfg_err_o, 0);
`ifdef DELAY_CTRL_TAP2_EN
        check("rst_data2_o", data2_o, 0);
        check("rst_valid2_o", valid2_o, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        en_i          = 1'b0;
        data_i        = '0;
        cfg_depth_i   = '0;
        cfg_load_i    = 1'b0;
        frame_start_i = 1'b0;
        flush_i       = 1'b0;
        model_reset();
        do_reset();

        // Fill at the default depth
        repeat (120) cyc(1, 0, 0, 0, 0);

        // Request depth 10, held pending for 100 cycles until the frame boundary
        cyc(1, 1, 10, 0, 0);
        repeat (100) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        repeat (40) cyc(1, 0, 0, 0, 0);

        // Out-of-range requests
        cyc(1, 1, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 65, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 60, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0);

        // Load coinciding with frame_start, first in RUN then in PEND
        cyc(1, 1, 40, 1, 0);
        repeat (5) cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 20, 1, 0);
        repeat (5) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        repeat (30) cyc(1, 0, 0, 0, 0);

        // Back to 40, last request wins while pending
        cyc(1, 1, 30, 0, 0);
        cyc(1, 1, 40, 0, 0);
        cyc(1, 0, 0, 1, 0);
        repeat (60) cyc(1, 0, 0, 0, 0);

        // Pseudo-random stalls
        repeat (300) cyc(1'($urandom_range(0, 1)), 0, 0, 0, 0);

        // Flush, then switch to the deepest allowed depth
        cyc(1, 0, 0, 0, 1);
        cyc(1, 1, MAX_CFG, 0, 0);
        cyc(1, 0, 0, 1, 0);
        repeat (100) cyc(1, 0, 0, 0, 0);
        repeat (150) cyc(1'($urandom_range(0, 1)), 0, 0, 0, 0);

        // Minimum depth, config acting while stalled
        cyc(0, 1, 2, 0, 0);
        cyc(0, 0, 0, 1, 0);
        repeat (40) cyc(1'($urandom_range(0, 1)), 0, 0, 0, 0);

        // Mixed random traffic
        repeat (800) begin
            cyc(1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, 80)),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 49) == 0));
        end

        // Reset with a request pending discards it
        cyc(1, 1, 12, 0, 0);
        do_reset();
        repeat (60) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        repeat (5) cyc(1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Runtime-programmable pixel delay line: circular buffer plus a pointer/config controller, replacing fixed-depth shift chains where alignment depth changes with video mode.
- Delays data_i by N enabled cycles; N is reprogrammed via a config pulse and takes effect only at a frame boundary, so no frame is torn.
- Sits between the pixel processing stages and the sync/timing path that must stay aligned with them.

Parameters:
- WIDTH, 24, data width (RGB888).
- MAX_DEPTH, 64, buffer entries and maximum delay; power of two.
- AW, 6, log2(MAX_DEPTH).
- DEFAULT_DEPTH, 40, active depth after reset; range 2..MAX_DEPTH.
- TAP2_OFFSET, 6, extra delay of the second tap (optional feature only).

Ports:
- clk_i  in  1  pixel clock.
- rst_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  advance enable; low = stall, all state held.
- data_i  in  WIDTH  pixel in.
- cfg_depth_i  in  AW+1  requested depth.
- cfg_load_i  in  1  one-cycle pulse; samples cfg_depth_i.
- frame_start_i  in  1  one-cycle frame boundary pulse.
- flush_i  in  1  one-cycle pulse; invalidates history.
- data_o  out  WIDTH  data_i delayed by active depth.
- valid_o  out  1  data_o holds real history.
- active_depth_o  out  AW+1  depth currently in use.
- pend_o  out  1  a depth change is pending.
- cfg_err_o  out  1  one-cycle pulse: rejected config.

Behaviour:
- Reset values (async): data_o=0, valid_o=0, active_depth_o=DEFAULT_DEPTH, pend_o=0, cfg_err_o=0, wr_ptr=0, hist_cnt=0, state=RUN.
- Datapath, on each en_i=1 cycle:
  - write data_i to mem[wr_ptr]; wr_ptr+1, wraps mod MAX_DEPTH.
  - hist_cnt+1, saturating at MAX_DEPTH.
  - Read address = wr_ptr-(D-1) mod MAX_DEPTH, so data_o is registered and lands exactly D enabled cycles after data_i.
  - With en_i=0, data_o, valid_o and all pointers hold.
- valid_o: registered; 1 when hist_cnt >= D (count before the increment, compared on an enabled cycle).
- Depth range: 2..MAX_DEPTH. Out-of-range cfg_depth_i on cfg_load_i -> cfg_err_o pulses next cycle; request ignored; state unchanged.
- FSM: RUN, PEND.
  - RUN + valid cfg_load_i -> latch pend_depth, go to PEND.
  - PEND + frame_start_i -> D=pend_depth, go to RUN.
  - PEND + valid cfg_load_i -> overwrite pend_depth (last request wins).
  - pend_o=1 in PEND.
- Depth switch does not flush: buffer keeps MAX_DEPTH history. After the switch, valid_o is re-evaluated against the new D. If the new D exceeds hist_cnt, valid_o drops until history covers it.
- frame_start_i and cfg_load_i in the same cycle:
  - in RUN: the request goes pending and applies at the NEXT frame_start_i.
  - in PEND: the old pend_depth is applied and the new request becomes pending; state stays PEND.
- frame_start_i and cfg_load_i act regardless of en_i.
- flush_i: hist_cnt=0, valid_o=0 next cycle; wr_ptr, D and pend state retained. flush_i has priority over the hist_cnt increment in the same cycle.
- Reset mid-operation discards any pending depth.

Optional Feature:
- Macro: DELAY_CTRL_TAP2_EN.
- Defined:
  - adds output data2_o [WIDTH-1:0] = data_i delayed D+TAP2_OFFSET enabled cycles.
  - adds output valid2_o, set when hist_cnt >= D+TAP2_OFFSET.
  - config check becomes 2 <= depth <= MAX_DEPTH-TAP2_OFFSET; violations pulse cfg_err_o.
  - both outputs reset to 0.
- Undefined: ports absent; full range 2..MAX_DEPTH accepted.

Test Plan:
- Reset, en_i=1, data_i=cycle index -> valid_o rises after 40 cycles; data_o=k-40 thereafter; active_depth_o=40.
- cfg_load_i with depth 10, frame_start_i 100 cycles later -> pend_o=1 for 100 cycles, data_o stays 40-delayed, then becomes 10-delayed; valid_o stays 1.
- cfg_load_i depth 1, then depth 65 -> cfg_err_o pulses once per request; active_depth_o and pend_o unchanged.
- Toggle en_i at 50% pseudo-random -> data_o equals the input sample 40 enabled cycles earlier; stalled cycles hold outputs.
- flush_i then immediate switch to depth 64 -> valid_o low for exactly 64 enabled cycles, then correct data.
- With DELAY_CTRL_TAP2_EN, D=40 -> data2_o = k-46, valid2_o rises 6 cycles after valid_o; depth 60 rejected with cfg_err_o.
